// File: rtl/udc.sv
// udc: registered main-control decoder mapping a 3-bit opcode to datapath control signals.
module udc (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       jump,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic       illegal
);
  // word order: alu_op, reg_dst, mem_to_reg, jump, branch, mem_read, mem_write, alu_src, reg_write, illegal
  logic [10:0] dec, ctl;
  always_comb begin
    dec = 11'b00_000000001;
    case (opcode)
      3'b000:  dec = 11'b10_100000010;
      3'b001:  dec = 11'b00_010010110;
      3'b010:  dec = 11'b00_000001100;
      3'b011:  dec = 11'b01_000100000;
      3'b100:  dec = 11'b00_001000000;
      3'b101:  dec = 11'b11_000000110;
      default: dec = 11'b00_000000001;
    endcase
  end
  always_ff @(posedge clk)
    ctl <= rst ? 11'd0 : dec;
  assign {alu_op, reg_dst, mem_to_reg, jump, branch, mem_read, mem_write, alu_src, reg_write, illegal} = ctl;
endmodule

// File: tb/tb_udc.sv
// tb_udc: directed and random checks of udc decode table, latency, reset and invariants.
module tb_udc;
  logic       clk = 0;
  logic       rst = 1;
  logic [2:0] opcode = 3'b001;
  logic [1:0] alu_op;
  logic reg_dst, mem_to_reg, jump, branch, mem_read, mem_write, alu_src, reg_write, illegal;
  int checks = 0, errors = 0;

  udc dut (.clk(clk), .rst(rst), .opcode(opcode), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .jump(jump), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .illegal(illegal));

  always #5 clk = ~clk;

  function automatic logic [10:0] row(input logic [2:0] op);
    logic [1:0] a; logic rd, m2r, j, b, mr, mw, as, rw, il;
    {a, rd, m2r, j, b, mr, mw, as, rw, il} = '0;
    if (op == 3'd0) begin a = 2'b10; rd = 1; rw = 1; end
    else if (op == 3'd1) begin m2r = 1; mr = 1; as = 1; rw = 1; end
    else if (op == 3'd2) begin mw = 1; as = 1; end
    else if (op == 3'd3) begin a = 2'b01; b = 1; end
    else if (op == 3'd4) j = 1;
    else if (op == 3'd5) begin a = 2'b11; as = 1; rw = 1; end
    else il = 1;
    return {a, rd, m2r, j, b, mr, mw, as, rw, il};
  endfunction

  function automatic logic [10:0] outs();
    return {alu_op, reg_dst, mem_to_reg, jump, branch, mem_read, mem_write, alu_src, reg_write, illegal};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] op);
    rst = r;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] op;
    logic [10:0] o;
    #1;
    step(1, 3'b001); check("reset0", outs(), 11'd0);
    step(1, 3'b001); check("reset1", outs(), 11'd0);
    for (int i = 0; i < 6; i++) begin
      op = 3'(i);
      step(0, op); check($sformatf("op%0d", i), outs(), row(op));
    end
    check("load_lit", row(3'd1), 11'b00_010010110);
    step(0, 3'b110); check("rsv110", outs(), 11'b00_000000001);
    step(0, 3'b111); check("rsv111", outs(), 11'b00_000000001);
    step(0, 3'b000); check("rtype_after_rsv", outs(), 11'b10_100000010);
    step(0, 3'b010); check("store_pre", outs(), 11'b00_000001100);
    step(1, 3'b010); check("store_rst", outs(), 11'd0);
    step(0, 3'b010); check("store_post", outs(), 11'b00_000001100);
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom_range(0, 7));
      step(0, op);
      o = outs();
      check("rand", o, row(op));
      check("inv", {11'd0} | {o[4] & o[3], o[6] & o[5], o[1] & (o[3] | o[5] | o[6]), o[7] & ~o[4]}, 11'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
